// File: rtl/pattern_pkg.sv
// Shared widths, word layout and FSM states for the pattern-load path.
// Used by pattern_encoder.
package pattern_pkg;

    localparam int PAT_W  = 16;
    localparam int IDX_W  = 4;
    localparam int NSLOT  = 4;
    localparam int WORD_W = 32;

    typedef struct packed {
        logic [IDX_W-1:0] slot3;
        logic [IDX_W-1:0] slot2;
        logic [IDX_W-1:0] slot1;
        logic [IDX_W-1:0] slot0;
        logic [PAT_W-1:0] pattern;
    } pattern_word_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        OUT
    } patenc_state_t;

endpackage

// File: rtl/pattern_encoder.sv
// Serially scans a don't-care mask and packs up to four wildcard indices
// with the pattern. PATENC_STRICT_EN: a zero mask is reported as an error.
module pattern_encoder
    import pattern_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PAT_W-1:0]  in_pattern,
    input  logic [PAT_W-1:0]  in_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic              out_err,
    output logic              out_lossy
);

    patenc_state_t state_q, state_d;

    logic [PAT_W-1:0]            pat_q, pat_d;
    logic [PAT_W-1:0]            mask_q, mask_d;
    logic [NSLOT-1:0][IDX_W-1:0] slot_q, slot_d;
    logic [2:0]                  cnt_q, cnt_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        err_q, err_d;

    logic [WORD_W-1:0] word_q;
    logic              oerr_q, lossy_q;

    logic                        last;
    logic                        zero;
    logic [NSLOT-1:0][IDX_W-1:0] fill;
    pattern_word_t               w;
    logic                        ferr, flossy;

    assign last = (state_q == SCAN) && (idx_q == 4'(PAT_W - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = SCAN;
            SCAN:    if (last) state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == OUT);
    end

    always_comb begin
        pat_d  = pat_q;
        mask_d = mask_q;
        slot_d = slot_q;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        err_d  = err_q;
        if (state_q == IDLE && in_valid) begin
            pat_d  = in_pattern;
            mask_d = in_mask;
            slot_d = '0;
            cnt_d  = 3'd0;
            idx_d  = '0;
            err_d  = 1'b0;
        end else if (state_q == SCAN) begin
            idx_d = idx_q + 4'd1;
            if (mask_q[idx_q]) begin
                if (cnt_q < 3'd4) begin
                    slot_d[cnt_q[1:0]] = idx_q;
                    pat_d[idx_q]       = 1'b0;
                    cnt_d              = cnt_q + 3'd1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    // Unused slots repeat slot 0 so the decoder sees no extra wildcard.
    always_comb begin
        zero = (cnt_d == 3'd0);
        for (int i = 0; i < NSLOT; i++) begin
            fill[i] = (3'(i) < cnt_d) ? slot_d[i] : slot_d[0];
        end
        w = '{slot3: fill[3], slot2: fill[2], slot1: fill[1],
              slot0: fill[0], pattern: pat_d};
        if (zero) w.pattern[0] = 1'b0;
`ifdef PATENC_STRICT_EN
        ferr   = err_d | zero;
        flossy = 1'b0;
`else
        ferr   = err_d;
        flossy = zero;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q   <= '0;
            mask_q  <= '0;
            slot_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            word_q  <= '0;
            oerr_q  <= 1'b0;
            lossy_q <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            mask_q <= mask_d;
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            err_q  <= err_d;
            if (last) begin
                word_q  <= w;
                oerr_q  <= ferr;
                lossy_q <= flossy;
            end
        end
    end

    assign out_word  = word_q;
    assign out_err   = oerr_q;
    assign out_lossy = lossy_q;

endmodule

// File: tb/tb_pattern_encoder.sv
// Scoreboard bench for pattern_encoder: directed cases plus random pairs
// checked against a wildcard-list reference model.
module tb_pattern_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_pattern = '0;
    logic [15:0] in_mask = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_word;
    logic        out_err;
    logic        out_lossy;

    pattern_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pattern (in_pattern),
        .in_mask    (in_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_err    (out_err),
        .out_lossy  (out_lossy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic        e;
        logic        l;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   rr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rr) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: list the set mask bits, keep the first four as wildcards.
    function automatic exp_t model(input logic [15:0] p, input logic [15:0] m);
        int   wild[$];
        int   s[4];
        exp_t r;
        for (int i = 0; i < 16; i++) if (m[i]) wild.push_back(i);
        for (int k = 0; k < 4; k++) begin
            if (k < wild.size()) begin
                s[k] = wild[k];
                p[wild[k]] = 1'b0;
            end else begin
                s[k] = (wild.size() > 0) ? wild[0] : 0;
            end
        end
        if (wild.size() == 0) p[0] = 1'b0;
        r.w = {s[3][3:0], s[2][3:0], s[1][3:0], s[0][3:0], p};
`ifdef PATENC_STRICT_EN
        r.e = (wild.size() > 4) || (wild.size() == 0);
        r.l = 1'b0;
`else
        r.e = (wild.size() > 4);
        r.l = (wild.size() == 0);
`endif
        return r;
    endfunction

    task automatic send(input logic [15:0] p, input logic [15:0] m,
                        input bit push, input exp_t e);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid   = 1'b1;
        in_pattern = p;
        in_mask    = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) sb.push_back(e);
    endtask

    function automatic exp_t mk(input logic [31:0] w, input logic e,
                                input logic l);
        exp_t r;
        r.w = w;
        r.e = e;
        r.l = l;
        return r;
    endfunction

    // Monitor: latency, stall stability and scoreboard pops.
    bit          prev_v = 1'b0;
    bit          stalled = 1'b0;
    logic [31:0] held_w;
    logic        held_e, held_l;

    always @(negedge clk) begin
        if (reset) begin
            prev_v  = 1'b0;
            stalled = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_cyc = cyc;
            if (out_valid && !prev_v) chk("latency", cyc - acc_cyc, 32'd17);
            if (out_valid) chk("in_ready_busy", 32'(in_ready), 32'd0);
            if (stalled) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_word", out_word, held_w);
                chk("stall_err", 32'(out_err), 32'(held_e));
                chk("stall_lossy", 32'(out_lossy), 32'(held_l));
            end
            if (out_valid && out_ready) begin
                stalled = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_word", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("word", out_word, e.w);
                    chk("err", 32'(out_err), 32'(e.e));
                    chk("lossy", 32'(out_lossy), 32'(e.l));
                end
            end else if (out_valid) begin
                stalled = 1'b1;
                held_w  = out_word;
                held_e  = out_err;
                held_l  = out_lossy;
            end
            prev_v = out_valid;
        end
    end

    initial begin
        exp_t        e0;
        logic [15:0] p, m;
        int          t;

        e0 = mk(32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_out_lossy", 32'(out_lossy), 32'd0);
        chk("rst_out_word", out_word, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        send(16'hA5F0, 16'h0081, 1'b1, mk(32'h0070A570, 1'b0, 1'b0));
        send(16'hFFFF, 16'hF000, 1'b1, mk(32'hFEDC0FFF, 1'b0, 1'b0));
        send(16'h1234, 16'h001F, 1'b1, mk(32'h32101230, 1'b1, 1'b0));
`ifdef PATENC_STRICT_EN
        send(16'hBEEF, 16'h0000, 1'b1, mk(32'h0000BEEE, 1'b1, 1'b0));
`else
        send(16'hBEEF, 16'h0000, 1'b1, mk(32'h0000BEEE, 1'b0, 1'b1));
`endif

        // Backpressure: ready low for five valid cycles, accept on the sixth.
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        out_ready = 1'b0;
        send(16'hA5F0, 16'h0081, 1'b1, mk(32'h0070A570, 1'b0, 1'b0));
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("bp_valid_seen", 32'(out_valid), 32'd1);
        repeat (5) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_out_valid", 32'(out_valid), 32'd0);

        // Reset during the scan of bit 8 discards the word.
        send(16'hCAFE, 16'h0F0F, 1'b0, e0);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midscan_out_valid", 32'(out_valid), 32'd0);
        chk("midscan_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        send(16'h00FF, 16'h0100, 1'b1, mk(32'h888800FF, 1'b0, 1'b0));

        rr = 1'b1;
        for (int n = 0; n < 40; n++) begin
            p = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       m = 16'h0;
                1:       m = 16'(1) << $urandom_range(0, 15);
                2:       m = 16'($urandom & $urandom & $urandom);
                default: m = 16'($urandom);
            endcase
            send(p, m, 1'b1, model(p, m));
        end

        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
